// File: rtl/bus_req_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module : bus_req_arbiter_pkg
// Brief  : Shared constants, types and round-robin pick helper for the arbiter.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package bus_req_arbiter_pkg;

    localparam int SW_ADDR_MSB  = 7;
    localparam int SW_ADDR_LSB  = 5;
    localparam int REG_ADDR_MSB = 4;
    localparam int OP_ID_W      = 8;
    localparam int MAX_REQ      = 8;
    localparam int RR_IDX_W     = 3;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of mask at or after ptr, wrapping at num (num <= MAX_REQ, ptr < num).
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]  mask,
                                         input logic [RR_IDX_W-1:0] ptr,
                                         input logic [RR_IDX_W:0]   num);
        rr_pick_t r;
        int       j;
        r = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= int'(num)) begin
                j = j - int'(num);
            end
            if ((k < int'(num)) && !r.found && mask[j[RR_IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = j[RR_IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_req_arbiter_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module : rr_arbiter
// Brief  : Combinational round-robin pick with a registered rotating pointer.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
    import bus_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req_mask,
    input  logic                advance,
    output logic [NUM_REQ-1:0]  grant,
    output logic [RR_IDX_W-1:0] grant_idx
);

    logic [RR_IDX_W-1:0] r_ptr;
    logic [MAX_REQ-1:0]  w_mask8;
    rr_pick_t            w_pick;

    always_comb begin
        w_mask8                = '0;
        w_mask8[NUM_REQ-1:0]   = req_mask;
        w_pick                 = rr_pick(w_mask8, r_ptr, (RR_IDX_W+1)'(NUM_REQ));
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = w_pick.found && (w_pick.idx == RR_IDX_W'(i));
        end
    end

    assign grant_idx = w_pick.idx;

    // Pointer moves just past the winner so it has lowest priority next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (advance) begin
            if (w_pick.idx == RR_IDX_W'(NUM_REQ-1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_pick.idx + RR_IDX_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_req_arbiter.sv
//------------------------------------------------------------------------------
// Module : bus_req_arbiter
// Brief  : Round-robin sharing of the bus_module request port with FIFO-full skip.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module bus_req_arbiter
    import bus_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int NUM_SW_INST = 5,
    parameter int W_WIDTH     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       arb_en,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_wr_rd,
    input  logic [8*NUM_REQ-1:0]       req_addr,
    input  logic [W_WIDTH*NUM_REQ-1:0] req_wr_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_SW_INST-1:0]     fifo_full,
    output logic                       bus_en,
    output logic                       bus_valid,
    output logic                       bus_wr_rd,
    output logic [OP_ID_W-1:0]         bus_op_id,
    output logic [7:0]                 bus_addr,
    output logic [W_WIDTH-1:0]         bus_wr_data,
    output logic                       err_valid,
    output logic [2:0]                 err_req_idx
);

    logic [7:0]          w_full8;
    logic [NUM_REQ-1:0]  w_elig;
    logic [NUM_REQ-1:0]  w_bad;
    logic [RR_IDX_W-1:0] w_idx;
    logic                w_xfer;
    logic                w_sel_wr;
    logic [7:0]          w_sel_addr;
    logic [W_WIDTH-1:0]  w_sel_data;
    logic                w_sel_bad;
    logic [OP_ID_W-1:0]  r_op_cnt;

    // Non-existent switches read as "not full" so bad addresses still get accepted.
    always_comb begin
        w_full8                  = '0;
        w_full8[NUM_SW_INST-1:0] = fifo_full;
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
            logic [2:0] w_sw;
            assign w_sw        = req_addr[8*gi+SW_ADDR_MSB : 8*gi+SW_ADDR_LSB];
            assign w_bad[gi]   = ({1'b0, w_sw} >= 4'(NUM_SW_INST));
            assign w_elig[gi]  = req_valid[gi] && arb_en && !w_full8[w_sw];
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_mask  (w_elig),
        .advance   (w_xfer),
        .grant     (req_ready),
        .grant_idx (w_idx)
    );

    assign w_xfer = |(req_valid & req_ready);

    always_comb begin
        w_sel_wr   = 1'b0;
        w_sel_addr = '0;
        w_sel_data = '0;
        w_sel_bad  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                w_sel_wr   = req_wr_rd[i];
                w_sel_addr = req_addr[8*i +: 8];
                w_sel_data = req_wr_data[W_WIDTH*i +: W_WIDTH];
                w_sel_bad  = w_bad[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_en      <= 1'b0;
            bus_valid   <= 1'b0;
            bus_wr_rd   <= 1'b0;
            bus_op_id   <= '0;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            err_valid   <= 1'b0;
            err_req_idx <= '0;
            r_op_cnt    <= '0;
        end else begin
            bus_en    <= arb_en;
            bus_valid <= 1'b0;
            err_valid <= 1'b0;
            if (w_xfer) begin
                if (w_sel_bad) begin
                    err_valid   <= 1'b1;
                    err_req_idx <= w_idx;
                end else begin
                    bus_valid   <= 1'b1;
                    bus_wr_rd   <= w_sel_wr;
                    bus_addr    <= w_sel_addr;
                    bus_wr_data <= w_sel_data;
                    bus_op_id   <= r_op_cnt;
                    r_op_cnt    <= r_op_cnt + OP_ID_W'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_req_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_bus_req_arbiter
// Brief  : Scoreboard bench for bus_req_arbiter against a round-robin model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bus_req_arbiter;

    localparam int NREQ = 4;
    localparam int NSW  = 5;
    localparam int WW   = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              arb_en = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_wr_rd = '0;
    logic [8*NREQ-1:0] req_addr = '0;
    logic [WW*NREQ-1:0] req_wr_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NSW-1:0]    fifo_full = '0;
    logic              bus_en, bus_valid, bus_wr_rd, err_valid;
    logic [7:0]        bus_op_id, bus_addr;
    logic [WW-1:0]     bus_wr_data;
    logic [2:0]        err_req_idx;

    bus_req_arbiter #(.NUM_REQ(NREQ), .NUM_SW_INST(NSW), .W_WIDTH(WW)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .arb_en      (arb_en),
        .req_valid   (req_valid),
        .req_wr_rd   (req_wr_rd),
        .req_addr    (req_addr),
        .req_wr_data (req_wr_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .bus_en      (bus_en),
        .bus_valid   (bus_valid),
        .bus_wr_rd   (bus_wr_rd),
        .bus_op_id   (bus_op_id),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .err_valid   (err_valid),
        .err_req_idx (err_req_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         err;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] id;
        logic [2:0] idx;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_ptr = 0;
    int   m_cnt = 0;
    logic m_en_exp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit m_bad(input int i);
        logic [7:0] a;
        a = req_addr[8*i +: 8];
        return int'(a[7:5]) >= NSW;
    endfunction

    function automatic bit m_elig(input int i);
        logic [7:0] a;
        int         sw;
        a  = req_addr[8*i +: 8];
        sw = int'(a[7:5]);
        if (!(req_valid[i] && arb_en)) return 1'b0;
        if (sw >= NSW) return 1'b1;
        return !fifo_full[sw];
    endfunction

    // Reference model: check last cycle's issue, then predict this cycle's grant.
    always @(negedge clk) begin
        exp_t            e;
        logic [NREQ-1:0] exp_ready;
        bit              found;
        int              j;
        if (!rst_n) begin
            sb.delete();
            m_ptr    = 0;
            m_cnt    = 0;
            m_en_exp = 1'b0;
        end else begin
            chk("bus_en", 32'(bus_en), 32'(m_en_exp));
            m_en_exp = arb_en;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.err) begin
                    chk("err_valid", 32'(err_valid), 32'd1);
                    chk("err_idx", 32'(err_req_idx), 32'(e.idx));
                    chk("bus_valid_on_err", 32'(bus_valid), 32'd0);
                end else begin
                    chk("bus_valid", 32'(bus_valid), 32'd1);
                    chk("err_on_issue", 32'(err_valid), 32'd0);
                    chk("bus_wr_rd", 32'(bus_wr_rd), 32'(e.wr));
                    chk("bus_addr", 32'(bus_addr), 32'(e.addr));
                    chk("bus_wr_data", 32'(bus_wr_data), 32'(e.data));
                    chk("bus_op_id", 32'(bus_op_id), 32'(e.id));
                end
            end else begin
                chk("idle_bus_valid", 32'(bus_valid), 32'd0);
                chk("idle_err_valid", 32'(err_valid), 32'd0);
            end
            exp_ready = '0;
            found     = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                j = (m_ptr + k) % NREQ;
                if (!found && m_elig(j)) begin
                    found        = 1'b1;
                    exp_ready[j] = 1'b1;
                    e.err  = m_bad(j);
                    e.wr   = req_wr_rd[j];
                    e.addr = req_addr[8*j +: 8];
                    e.data = req_wr_data[WW*j +: WW];
                    e.id   = 8'(m_cnt);
                    e.idx  = 3'(j);
                    sb.push_back(e);
                    m_ptr = (j + 1) % NREQ;
                    if (!e.err) m_cnt = (m_cnt + 1) % 256;
                end
            end
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [7:0] a, input logic [7:0] d);
        req_wr_rd[i]         = wr;
        req_addr[8*i +: 8]   = a;
        req_wr_data[WW*i +: WW] = d;
        req_valid[i]         = 1'b1;
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_bus_valid", 32'(bus_valid), 32'd0);
        chk("rst_bus_op_id", 32'(bus_op_id), 32'd0);
        chk("rst_bus_en", 32'(bus_en), 32'd0);
        chk("rst_err_valid", 32'(err_valid), 32'd0);
        tick();
        rst_n  = 1'b1;
        arb_en = 1'b1;
        tick();

        // Single write from requester 0
        set_req(0, 1'b1, 8'h43, 8'hA5);
        #1 chk("t1_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        chk("t1_valid", 32'(bus_valid), 32'd1);
        chk("t1_addr", 32'(bus_addr), 32'h43);
        chk("t1_data", 32'(bus_wr_data), 32'hA5);
        chk("t1_wr", 32'(bus_wr_rd), 32'd1);
        chk("t1_id", 32'(bus_op_id), 32'd0);
        tick();

        // All four requesters continuously valid
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, i[0], 8'(i), 8'(8'h10 + i));
        for (int c = 0; c < 6; c++) begin
            #1 chk("t2_ready", 32'(req_ready), 32'(1 << (c % 4)));
            tick();
            chk("t2_id", 32'(bus_op_id), 32'(c));
        end
        req_valid = '0;
        arb_en    = 1'b0;
        tick();
        arb_en = 1'b1;
        tick();

        // Full FIFO on switch 2 stalls requester 0
        fifo_full = 5'b00100;
        set_req(0, 1'b0, 8'h45, 8'h11);
        set_req(1, 1'b1, 8'h21, 8'h22);
        #1 chk("t3_ready_r1", 32'(req_ready), 32'b0010);
        tick();
        req_valid[1] = 1'b0;
        #1 chk("t3_stalled", 32'(req_ready), 32'b0000);
        fifo_full = '0;
        #1 chk("t3_ready_r0", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        tick();

        // Address on a nonexistent switch
        set_req(2, 1'b1, 8'hE0, 8'h33);
        #1 chk("t4_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        chk("t4_err", 32'(err_valid), 32'd1);
        chk("t4_err_idx", 32'(err_req_idx), 32'd2);
        chk("t4_bus_valid", 32'(bus_valid), 32'd0);
        set_req(3, 1'b0, 8'h02, 8'h44);
        tick();
        req_valid = '0;
        tick();

        // op_id wrap over 257 issues
        do_reset();
        set_req(0, 1'b1, 8'h01, 8'h55);
        for (int c = 0; c < 257; c++) begin
            tick();
            if (c >= 254) chk("t5_wrap_id", 32'(bus_op_id), 32'(c % 256));
        end
        req_valid = '0;
        tick();

        // Mid-operation reset, then arb_en low blocks grants
        set_req(1, 1'b1, 8'h03, 8'h66);
        tick();
        req_valid = '0;
        chk("t6_pre_valid", 32'(bus_valid), 32'd1);
        rst_n  = 1'b0;
        arb_en = 1'b0;
        #1 chk("t6_rst_valid", 32'(bus_valid), 32'd0);
        chk("t6_rst_addr", 32'(bus_addr), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 8'(8'h08 + i), 8'(8'h70 + i));
        for (int c = 0; c < 3; c++) begin
            #1 chk("t6_blocked", 32'(req_ready), 32'd0);
            tick();
        end
        arb_en = 1'b1;
        #1 chk("t6_ptr0", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        chk("t6_id0", 32'(bus_op_id), 32'd0);
        tick();
        tick();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
